ecall_service_unit: RTL and testbench
=====================================

ECALL_SERVICE_UNIT -- requirements
Module: ecall_service_unit

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 20'd1_000_000, stable cycles required on confirm.
REQ-002 SHALL have parameter FINISH_HOLD, default 2, cycles finish is held high (minimum 2).
REQ-003 SHALL have ports: clk  in  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ecall  in  1  service request level from the CPU stall logic.
REQ-006 a7  in  32  service code; a0  in  32  service argument.
REQ-007 confirm  in  1  raw user confirm button; switches  in  16  user input value.
REQ-008 finish  out  1  service-complete level back to the stall logic.
REQ-009 rd_we  out  1  one-cycle a0 write strobe; rd_data  out  32  value written to a0.
REQ-010 disp_data  out  32  seven-segment value; led  out  16  LED bank; halted  out  1  program exited.

Function
REQ-011 FSM states: IDLE, DECODE, WAIT_BTN, WRITEBACK, FINISH, RELEASE, HALT.
REQ-012 IDLE -> DECODE on first cycle ecall=1; a7 and a0 captured into internal registers on that edge.
REQ-013 DECODE, a7=1 (print int): disp_data <= captured a0; next FINISH.
REQ-014 DECODE, a7=34 (LED): led <= captured a0[15:0]; next FINISH.
REQ-015 DECODE, a7=5 (read int): next WAIT_BTN; a7=10 (exit): halted <= 1, next HALT.
REQ-016 DECODE, any other a7: no output change, next FINISH (unknown service never hangs the CPU).
REQ-017 WAIT_BTN -> WRITEBACK on a confirm press event (rising edge of the conditioned confirm); held button yields one event only.
REQ-018 WRITEBACK: rd_data <= sign-extended switches, rd_we = 1 for exactly this cycle; next FINISH.
REQ-019 FINISH: finish = 1 for exactly FINISH_HOLD consecutive cycles (down-counter), then RELEASE.
REQ-020 RELEASE: finish = 0; stay until ecall = 0, then IDLE; prevents re-triggering on the same ecall.
REQ-021 HALT: terminal until reset; finish stays 0, ecall ignored, halted = 1.
REQ-022 ecall falling during DECODE/WAIT_BTN/WRITEBACK SHALL abort to IDLE without rd_we or finish; outputs already updated stay.
REQ-023 Latency: print/LED/unknown ecall rise -> finish rise = 3 cycles; read = 2 cycles after press event.
REQ-024 confirm press while not in WAIT_BTN SHALL be discarded (no queued events).

Reset
REQ-025 On rst_n = 0: state IDLE; finish, rd_we, halted = 0; rd_data, disp_data = 32'h0; led = 16'h0; counters and captured registers = 0.
REQ-026 Reset asserted mid-service SHALL return to IDLE immediately; release takes effect on the next rising clk edge.

Configuration
REQ-027 Macro ECALL_DEBOUNCE_EN defined: confirm passes 2-flop synchronizer plus debouncer (level must be stable DEBOUNCE_CYCLES cycles) before edge detection.
REQ-028 ECALL_DEBOUNCE_EN undefined: 2-flop synchronizer plus edge detection only; DEBOUNCE_CYCLES unused.

Structure
REQ-029 Service codes (1, 5, 10, 34) and state encodings SHALL live in the shared parameters include file beside the existing opcode defines.
REQ-030 One sub-module, button_debouncer (synchronizer, stable counter, press-pulse output), instantiated only under ECALL_DEBOUNCE_EN.

Verification
REQ-031 a7=1, a0=32'h0000_1234, ecall high -> disp_data=32'h1234 and finish high cycles 3-4 after ecall rise; no rd_we.
REQ-032 a7=5, switches=16'h8001, press confirm -> one rd_we pulse, rd_data=32'hFFFF_8001, then finish 2 cycles.
REQ-033 a7=5, confirm held high 50 cycles, ecall held high through RELEASE -> exactly one rd_we, one finish burst, no re-entry.
REQ-034 a7=10 -> halted=1, finish never rises; later ecall with a7=1 leaves disp_data unchanged.
REQ-035 a7=7 (unknown) -> finish burst, all data outputs unchanged; rst_n low during WAIT_BTN -> all outputs zero, state IDLE.
REQ-036 With ECALL_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: 3-cycle glitch on confirm -> no event; 10-cycle press -> one event.

Source files
------------

// File: rtl/ecall_service_unit_pkg.sv
// ecall_service_unit_pkg
// Shared constants for the ecall service unit: the service codes found in a7,
// the FSM state encodings, and a small sign-extension helper for read-int.
package ecall_service_unit_pkg;

  // Service codes carried in a7
  localparam logic [31:0] SVC_PRINT_INT = 32'd1;
  localparam logic [31:0] SVC_READ_INT  = 32'd5;
  localparam logic [31:0] SVC_EXIT      = 32'd10;
  localparam logic [31:0] SVC_LED       = 32'd34;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_WAIT_BTN  = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;
  localparam logic [2:0] ST_RELEASE   = 3'd5;
  localparam logic [2:0] ST_HALT      = 3'd6;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/ecall_service_unit_button_debouncer.sv
// button_debouncer
// Conditions a raw push-button: 2-flop synchronizer, then a stable-level
// filter that accepts a new level only after it has been seen for
// STABLE_CYCLES consecutive cycles, then a one-cycle press pulse on each
// accepted 0->1 transition.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   btn_raw  in   raw button level (asynchronous to clk)
//   press    out  one-cycle pulse per accepted press
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 20'd1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam logic [31:0] CNT_LOAD = (STABLE_CYCLES > 0) ? 32'(STABLE_CYCLES - 1) : 32'd0;

  logic [1:0]  sync_q,   sync_d;
  logic        stable_q, stable_d;
  logic [31:0] cnt_q,    cnt_d;
  logic        press_q,  press_d;

  // The down-counter is reloaded whenever the synchronized level agrees with
  // the accepted level, so any bounce restarts the stability window.
  always_comb begin
    sync_d   = {sync_q[0], btn_raw};
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync_q[1] == stable_q) begin
      cnt_d = CNT_LOAD;
    end else if (cnt_q == 32'd0) begin
      stable_d = sync_q[1];
      press_d  = sync_q[1];
      cnt_d    = CNT_LOAD;
    end else begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= 32'd0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/ecall_service_unit.sv
// ecall_service_unit
// Services CPU ecalls: print-int to the seven-segment display, LED write,
// read-int from the switches (waits for a confirm press), exit (halts), and
// acknowledges any other code without side effects. finish is held for
// FINISH_HOLD cycles, then the unit waits for ecall to drop before rearming.
// Build option: define ECALL_DEBOUNCE_EN to debounce confirm (stable for
// DEBOUNCE_CYCLES cycles); otherwise confirm is only synchronized and
// edge-detected.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ecall, a7, a0       request level, service code, argument
//   confirm, switches   raw confirm button, user input value
//   finish              service-complete level
//   rd_we, rd_data      one-cycle a0 write strobe and value
//   disp_data, led      seven-segment value, LED bank
//   halted              program has exited
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | waiting for ecall; a7/a0 captured on the rising edge
// ST_DECODE    | act on the captured service code
// ST_WAIT_BTN  | read-int: waiting for a confirm press event
// ST_WRITEBACK | read-int: sample switches, strobe rd_we
// ST_FINISH    | counting down the finish burst
// ST_RELEASE   | finish done; wait for ecall to drop
// ST_HALT      | program exited; terminal until reset
module ecall_service_unit
  import ecall_service_unit_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter int unsigned FINISH_HOLD     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ecall,
  input  logic [31:0] a7,
  input  logic [31:0] a0,
  input  logic        confirm,
  input  logic [15:0] switches,
  output logic        finish,
  output logic        rd_we,
  output logic [31:0] rd_data,
  output logic [31:0] disp_data,
  output logic [15:0] led,
  output logic        halted
);

  localparam logic [31:0] FIN_LOAD = 32'(FINISH_HOLD - 1);

  logic press;

`ifdef ECALL_DEBOUNCE_EN
  button_debouncer #(
    .STABLE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(confirm),
    .press  (press)
  );
`else
  logic [1:0] confirm_sync_q, confirm_sync_d;
  logic       confirm_prev_q, confirm_prev_d;

  always_comb begin
    confirm_sync_d = {confirm_sync_q[0], confirm};
    confirm_prev_d = confirm_sync_q[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      confirm_sync_q <= 2'b00;
      confirm_prev_q <= 1'b0;
    end else begin
      confirm_sync_q <= confirm_sync_d;
      confirm_prev_q <= confirm_prev_d;
    end
  end

  assign press = confirm_sync_q[1] & ~confirm_prev_q;
`endif

  logic [2:0]  state_q,   state_d;
  logic [31:0] a7_q,      a7_d;
  logic [31:0] a0_q,      a0_d;
  logic [31:0] fin_cnt_q, fin_cnt_d;
  logic        finish_q,  finish_d;
  logic        rd_we_q,   rd_we_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [31:0] disp_q,    disp_d;
  logic [15:0] led_q,     led_d;
  logic        halted_q,  halted_d;

  // All outputs are registered so the stall logic sees glitch-free levels;
  // finish and rd_we therefore trail their FSM states by one cycle.
  always_comb begin
    state_d   = state_q;
    a7_d      = a7_q;
    a0_d      = a0_q;
    fin_cnt_d = fin_cnt_q;
    rd_data_d = rd_data_q;
    disp_d    = disp_q;
    led_d     = led_q;
    halted_d  = halted_q;
    finish_d  = 1'b0;
    rd_we_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ecall) begin
          a7_d    = a7;
          a0_d    = a0;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!ecall) begin
          state_d = ST_IDLE;
        end else begin
          case (a7_q)
            SVC_PRINT_INT: begin
              disp_d    = a0_q;
              fin_cnt_d = FIN_LOAD;
              state_d   = ST_FINISH;
            end
            SVC_LED: begin
              led_d     = a0_q[15:0];
              fin_cnt_d = FIN_LOAD;
              state_d   = ST_FINISH;
            end
            SVC_READ_INT: state_d = ST_WAIT_BTN;
            SVC_EXIT: begin
              halted_d = 1'b1;
              state_d  = ST_HALT;
            end
            default: begin
              fin_cnt_d = FIN_LOAD;
              state_d   = ST_FINISH;
            end
          endcase
        end
      end
      ST_WAIT_BTN: begin
        if (!ecall)     state_d = ST_IDLE;
        else if (press) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        if (!ecall) begin
          state_d = ST_IDLE;
        end else begin
          rd_data_d = sext16(switches);
          rd_we_d   = 1'b1;
          fin_cnt_d = FIN_LOAD;
          state_d   = ST_FINISH;
        end
      end
      ST_FINISH: begin
        finish_d = 1'b1;
        if (fin_cnt_q == 32'd0) state_d = ST_RELEASE;
        else                    fin_cnt_d = fin_cnt_q - 32'd1;
      end
      ST_RELEASE: begin
        if (!ecall) state_d = ST_IDLE;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a7_q      <= 32'h0;
      a0_q      <= 32'h0;
      fin_cnt_q <= 32'h0;
      finish_q  <= 1'b0;
      rd_we_q   <= 1'b0;
      rd_data_q <= 32'h0;
      disp_q    <= 32'h0;
      led_q     <= 16'h0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a7_q      <= a7_d;
      a0_q      <= a0_d;
      fin_cnt_q <= fin_cnt_d;
      finish_q  <= finish_d;
      rd_we_q   <= rd_we_d;
      rd_data_q <= rd_data_d;
      disp_q    <= disp_d;
      led_q     <= led_d;
      halted_q  <= halted_d;
    end
  end

  assign finish    = finish_q;
  assign rd_we     = rd_we_q;
  assign rd_data   = rd_data_q;
  assign disp_data = disp_q;
  assign led       = led_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_ecall_service_unit.sv
// tb_ecall_service_unit
// Self-checking bench: directed service scenarios plus randomized service
// requests, checked against a transaction-level model of the service rules.
module tb_ecall_service_unit;

  localparam int DB   = 8;
  localparam int HOLD = 2;
`ifdef ECALL_DEBOUNCE_EN
  localparam int EV_LAT    = 2 + DB;
  localparam int MIN_PRESS = DB + 2;
`else
  localparam int EV_LAT    = 2;
  localparam int MIN_PRESS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ecall = 1'b0;
  logic [31:0] a7 = '0;
  logic [31:0] a0 = '0;
  logic        confirm = 1'b0;
  logic [15:0] switches = '0;
  logic        finish, rd_we, halted;
  logic [31:0] rd_data, disp_data;
  logic [15:0] led;

  ecall_service_unit #(
    .DEBOUNCE_CYCLES(DB),
    .FINISH_HOLD    (HOLD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ecall    (ecall),
    .a7       (a7),
    .a0       (a0),
    .confirm  (confirm),
    .switches (switches),
    .finish   (finish),
    .rd_we    (rd_we),
    .rd_data  (rd_data),
    .disp_data(disp_data),
    .led      (led),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the architecturally visible outputs
  logic [31:0] m_disp    = '0;
  logic [31:0] m_rd_data = '0;
  logic [15:0] m_led     = '0;
  logic        m_halted  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_disp"},    disp_data,       m_disp);
    chk({tag, "_led"},     {16'h0, led},    {16'h0, m_led});
    chk({tag, "_rd_data"}, rd_data,         m_rd_data);
    chk({tag, "_halted"},  {31'h0, halted}, {31'h0, m_halted});
  endtask

  task automatic watch(input int n, output int we_n, output int fin_n);
    we_n = 0;
    fin_n = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rd_we === 1'b1)  we_n++;
      if (finish === 1'b1) fin_n++;
    end
  endtask

  function automatic logic [31:0] rand_unknown();
    logic [31:0] v;
    do v = $urandom; while (v == 1 || v == 5 || v == 10 || v == 34);
    return v;
  endfunction

  // One complete ecall. Cycle k counts negedges after ecall is raised; confirm
  // (read only) rises at k=p for len cycles; ecall is dropped hold cycles after
  // the finish burst ends (or at k=12 if no finish is expected).
  task automatic run_service(input logic [31:0] code, input logic [31:0] arg,
                             input logic [15:0] sw, input int p, input int len,
                             input int hold, input string tag);
    bit is_read, expect_finish, done;
    int fin_n, fin_first, fin_last, we_n, we_k, drop_k, k;
    logic [31:0] we_data;
    is_read       = (code == 32'd5) && !m_halted;
    expect_finish = !m_halted && (code != 32'd10);
    fin_n = 0; fin_first = -1; fin_last = -1; we_n = 0; we_k = -1; drop_k = -1;
    k = 0; done = 0; we_data = '0;
    if (!m_halted) begin
      case (code)
        32'd1:   m_disp = arg;
        32'd34:  m_led = arg[15:0];
        32'd5:   m_rd_data = {{16{sw[15]}}, sw};
        32'd10:  m_halted = 1'b1;
        default: ;
      endcase
    end
    a7 = code; a0 = arg; switches = sw; confirm = 1'b0; ecall = 1'b1;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
      if (finish === 1'b1) begin
        fin_n++;
        if (fin_first < 0) fin_first = k;
        fin_last = k;
      end
      if (rd_we === 1'b1) begin
        we_n++;
        we_k = k;
        we_data = rd_data;
      end
      if (is_read) confirm = (k >= p && k < p + len);
      if (drop_k < 0) begin
        if (expect_finish ? (fin_n > 0 && finish !== 1'b1 && k >= fin_last + hold) : (k >= 12)) begin
          ecall = 1'b0;
          drop_k = k;
        end
      end else if (k >= drop_k + 4 && (!is_read || k >= p + len)) begin
        done = 1;
      end
    end
    confirm = 1'b0;
    ecall = 1'b0;
    chk({tag, "_done"},  {31'h0, done}, 32'd1);
    chk({tag, "_fin_n"}, 32'(fin_n), expect_finish ? 32'(HOLD) : 32'd0);
    if (expect_finish)
      chk({tag, "_fin_lat"}, 32'(fin_first), is_read ? 32'(p + EV_LAT + 3) : 32'd3);
    chk({tag, "_we_n"}, 32'(we_n), is_read ? 32'd1 : 32'd0);
    if (is_read) begin
      chk({tag, "_we_lat"},  32'(we_k), 32'(p + EV_LAT + 2));
      chk({tag, "_we_data"}, we_data,   m_rd_data);
    end
    chk_outputs(tag);
    repeat (DB + 6) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_a, fin_a, we_b, fin_b, sel;
    logic [31:0] code;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_finish", {31'h0, finish}, 32'd0);
    chk("rst_rd_we",  {31'h0, rd_we},  32'd0);
    chk_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Print int, read int, held confirm, unknown code
    run_service(32'd1, 32'h0000_1234, 16'h0, 0, 0, 1, "print");
    run_service(32'd5, $urandom, 16'h8001, 3, MIN_PRESS + 1, 2, "read");
    run_service(32'd5, $urandom, 16'h1234, 4, 50, 10, "held");
    run_service(32'd34, 32'hABCD_5A5A, 16'h0, 0, 0, 3, "led");
    run_service(32'd7, $urandom, $urandom, 0, 0, 2, "unknown");

    // Press while idle is discarded; ecall dropped in WAIT_BTN aborts silently
    confirm = 1'b1;
    watch(MIN_PRESS + 2, we_a, fin_a);
    confirm = 1'b0;
    watch(DB + 6, we_a, fin_a);
    a7 = 32'd5; a0 = $urandom; switches = 16'h7777; ecall = 1'b1;
    watch(20, we_a, fin_a);
    ecall = 1'b0;
    watch(6, we_b, fin_b);
    chk("discard_we_n",  32'(we_a + we_b),  32'd0);
    chk("abort_fin_n",   32'(fin_a + fin_b), 32'd0);
    chk_outputs("abort");
    run_service(32'd1, 32'hCAFE_0001, 16'h0, 0, 0, 1, "after_abort");

`ifdef ECALL_DEBOUNCE_EN
    // Short glitch rejected, long press accepted once
    a7 = 32'd5; a0 = $urandom; switches = 16'hF00F; ecall = 1'b1;
    watch(4, we_a, fin_a);
    confirm = 1'b1;
    watch(3, we_a, fin_a);
    confirm = 1'b0;
    watch(20, we_b, fin_b);
    chk("glitch_we_n", 32'(we_a + we_b), 32'd0);
    confirm = 1'b1;
    watch(10, we_a, fin_a);
    confirm = 1'b0;
    watch(15, we_b, fin_b);
    m_rd_data = 32'hFFFF_F00F;
    chk("press10_we_n",  32'(we_a + we_b),   32'd1);
    chk("press10_fin_n", 32'(fin_a + fin_b), 32'(HOLD));
    ecall = 1'b0;
    watch(DB + 6, we_a, fin_a);
    chk_outputs("press10");
`endif

    // Randomized service mix
    for (int t = 0; t < 25; t++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       code = 32'd1;
        1:       code = 32'd34;
        2:       code = 32'd5;
        3:       code = 32'd7;
        default: code = rand_unknown();
      endcase
      run_service(code, $urandom, 16'($urandom), $urandom_range(1, 8),
                  $urandom_range(MIN_PRESS, MIN_PRESS + 4), $urandom_range(1, 6), "rand");
    end

    // Reset asserted while waiting for the button
    a7 = 32'd5; a0 = $urandom; switches = 16'h1111; ecall = 1'b1;
    watch(4, we_a, fin_a);
    rst_n = 1'b0;
    #1;
    m_disp = '0; m_led = '0; m_rd_data = '0; m_halted = 1'b0;
    chk("midrst_finish", {31'h0, finish}, 32'd0);
    chk("midrst_rd_we",  {31'h0, rd_we},  32'd0);
    chk_outputs("midrst");
    ecall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_service(32'd1, 32'h0BAD_F00D, 16'h0, 0, 0, 1, "post_rst");

    // Exit is terminal; a later print is ignored
    run_service(32'd10, $urandom, 16'h0, 0, 0, 1, "exit");
    run_service(32'd1, 32'h5555_AAAA, 16'h0, 0, 0, 1, "after_exit");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
